ram_sync_nr2w_clr: RTL and testbench
====================================

RAM_SYNC_NR2W_CLR -- requirements
Module: ram_sync_nr2w_clr

Interface
REQ-001 SHALL have parameter BRAM_ADDR_WIDTH, default `ADDR_LEN: address width for every port.
REQ-002 SHALL have parameter BRAM_DATA_WIDTH, default `DATA_LEN: data width for every port.
REQ-003 SHALL have parameter DATA_DEPTH, default 32: number of entries, 1..2^BRAM_ADDR_WIDTH, not necessarily a power of two.
REQ-004 SHALL have parameter NUM_RPORTS, default 6: number of read ports, 1..8.
REQ-005 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 gives plain read-before-write.
REQ-006 SHALL have parameter CLEAR_VALUE, default 0: value written by the clear sweep.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge.
REQ-008 SHALL have port reset_x, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port raddr, input, NUM_RPORTS*BRAM_ADDR_WIDTH bits: packed read addresses; port i uses slice i.
REQ-010 SHALL have port rdata, output reg, NUM_RPORTS*BRAM_DATA_WIDTH bits: packed read data; port i uses slice i.
REQ-011 SHALL have ports waddr1/waddr2, input, BRAM_ADDR_WIDTH bits each: write addresses.
REQ-012 SHALL have ports wdata1/wdata2, input, BRAM_DATA_WIDTH bits each: write data.
REQ-013 SHALL have ports we1/we2, input, 1 bit each: write enables.
REQ-014 SHALL have port clr_req, input, 1 bit: pulse that starts a full clear sweep.
REQ-015 SHALL have port ready, output, 1 bit: high when in IDLE, low while a sweep is in progress.

Function
REQ-016 SHALL register read data with latency 1: rdata[i] after edge N reflects raddr[i] sampled at edge N.
REQ-017 SHALL, in IDLE with BYPASS=1, return wdata2 when we2 is high and waddr2==raddr[i]; otherwise wdata1 when we1 is high and waddr1==raddr[i]; otherwise mem[raddr[i]].
REQ-018 SHALL, with BYPASS=0, return the pre-write contents of mem[raddr[i]].
REQ-019 SHALL, when we1 and we2 are both high to the same address, store wdata2 (port 2 wins); bypass priority SHALL match this.
REQ-020 SHALL ignore writes whose address is >= DATA_DEPTH, and SHALL return CLEAR_VALUE for reads whose address is >= DATA_DEPTH.
REQ-021 SHALL implement a two-state FSM, IDLE and CLEAR, with clear counter clr_addr of width BRAM_ADDR_WIDTH.
REQ-022 SHALL, in CLEAR, write CLEAR_VALUE to mem[clr_addr] each cycle and increment clr_addr.
REQ-023 SHALL transition CLEAR->IDLE on the edge that writes clr_addr==DATA_DEPTH-1, so a sweep lasts exactly DATA_DEPTH cycles.
REQ-024 SHALL transition IDLE->CLEAR on clr_req=1 with clr_addr<=0; writes presented in that same cycle SHALL still be performed.
REQ-025 SHALL, while in CLEAR, ignore we1/we2 and clr_req, and drive every rdata slice to CLEAR_VALUE.
REQ-026 SHALL drive ready combinationally from the state: (state==IDLE).

Reset
REQ-027 SHALL, on reset_x=0 asynchronously, set state=CLEAR, clr_addr=0, and every rdata slice to CLEAR_VALUE; ready=0.
REQ-028 SHALL, after reset_x deassertion, perform a full sweep before ready rises; reset asserted mid-sweep SHALL restart the sweep at address 0.
REQ-029 SHALL NOT reset the memory array asynchronously; only the sweep clears it.

Structure
REQ-030 SHALL place the FSM state encodings (IDLE, CLEAR) in the shared constants header.
REQ-031 SHALL implement the FSM and counter in one sub-module, ram_clear_ctrl, with outputs clr_we, clr_addr and ready.
REQ-032 SHALL build the read ports with a generate loop over NUM_RPORTS sharing one write path; total RTL SHALL be within 120-400 lines.

Verification
REQ-033 SHALL cover reset and sweep: DATA_DEPTH=32, release reset -> ready low for exactly 32 cycles; afterwards all 32 addresses read 0.
REQ-034 SHALL cover write then read: we1 writes addr 5=0xDEAD; read addr 5 on the next cycle -> rdata[0]=0xDEAD one cycle later.
REQ-035 SHALL cover bypass: same-cycle we1 addr 3=0x11 with raddr[2]=3 -> BYPASS=1 gives 0x11; BYPASS=0 gives the old value.
REQ-036 SHALL cover write collision: we1 and we2 both to addr 7 with 0xA/0xB -> bypassed read and later read both return 0xB.
REQ-037 SHALL cover clr_req during traffic: issue clr_req, then writes during the sweep -> writes ignored, ready low 32 cycles, all entries 0 afterwards.
REQ-038 SHALL cover reset mid-sweep: assert reset_x at sweep cycle 10 -> sweep restarts at 0 and ready rises 32 cycles after release; DATA_DEPTH=20 with ADDR width 5 -> address 25 reads CLEAR_VALUE.

Source files
------------

// File: rtl/ram_sync_nr2w_clr_pkg.sv
// Shared constants for the multi-read, dual-write RAM with clear sweep.
package ram_sync_nr2w_clr_pkg;

    localparam int unsigned ADDR_LEN = 5;
    localparam int unsigned DATA_LEN = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear-sweep controller: walks clr_addr over every entry once per clear request or reset.
module ram_clear_ctrl
    import ram_sync_nr2w_clr_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_LEN,
    parameter int unsigned DATA_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset_x,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DATA_DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    // Reset lands in CLEAR so the array is swept before first use.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                clr_addr_d = '0;
            end
        endcase
    end

    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_addr = clr_addr_q;
    assign ready    = (state_q == ST_IDLE);

endmodule

// File: rtl/ram_sync_nr2w_clr.sv
// Synchronous RAM with NUM_RPORTS registered read ports, two write ports and a clear sweep.
module ram_sync_nr2w_clr
    import ram_sync_nr2w_clr_pkg::*;
#(
    parameter int unsigned BRAM_ADDR_WIDTH = ADDR_LEN,
    parameter int unsigned BRAM_DATA_WIDTH = DATA_LEN,
    parameter int unsigned DATA_DEPTH      = 32,
    parameter int unsigned NUM_RPORTS      = 6,
    parameter int unsigned BYPASS          = 1,
    parameter logic [BRAM_DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                                  clk,
    input  logic                                  reset_x,
    input  logic [NUM_RPORTS*BRAM_ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RPORTS*BRAM_DATA_WIDTH-1:0] rdata,
    input  logic [BRAM_ADDR_WIDTH-1:0]            waddr1,
    input  logic [BRAM_ADDR_WIDTH-1:0]            waddr2,
    input  logic [BRAM_DATA_WIDTH-1:0]            wdata1,
    input  logic [BRAM_DATA_WIDTH-1:0]            wdata2,
    input  logic                                  we1,
    input  logic                                  we2,
    input  logic                                  clr_req,
    output logic                                  ready
);

    localparam int unsigned AW    = BRAM_ADDR_WIDTH;
    localparam int unsigned DW    = BRAM_DATA_WIDTH;
    localparam int unsigned IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DATA_DEPTH);

    logic [DW-1:0] mem [DATA_DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr1_ok, wr2_ok;

    ram_clear_ctrl #(
        .ADDR_W     (AW),
        .DATA_DEPTH (DATA_DEPTH)
    ) u_clear_ctrl (
        .clk      (clk),
        .reset_x  (reset_x),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    assign wr1_ok = we1 && ({1'b0, waddr1} < DEPTH_LIM);
    assign wr2_ok = we2 && ({1'b0, waddr2} < DEPTH_LIM);

    // Shared write path; port 2 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[IDX_W'(clr_addr)] <= CLEAR_VALUE;
        end else begin
            if (wr1_ok) mem[IDX_W'(waddr1)] <= wdata1;
            if (wr2_ok) mem[IDX_W'(waddr2)] <= wdata2;
        end
    end

    for (genvar i = 0; i < int'(NUM_RPORTS); i++) begin : g_rport
        logic [AW-1:0] ra;
        logic [DW-1:0] rdata_d, rdata_q;

        assign ra = raddr[i*AW +: AW];

        // Forwarding priority mirrors the write-path collision rule.
        always_comb begin
            rdata_d = CLEAR_VALUE;
            if ({1'b0, ra} < DEPTH_LIM) begin
                if ((BYPASS != 0) && wr2_ok && (waddr2 == ra)) begin
                    rdata_d = wdata2;
                end else if ((BYPASS != 0) && wr1_ok && (waddr1 == ra)) begin
                    rdata_d = wdata1;
                end else begin
                    rdata_d = mem[IDX_W'(ra)];
                end
            end
        end

        always_ff @(posedge clk or negedge reset_x) begin
            if (!reset_x) begin
                rdata_q <= CLEAR_VALUE;
            end else if (clr_we) begin
                rdata_q <= CLEAR_VALUE;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata[i*DW +: DW] = rdata_q;
    end

endmodule

// File: tb/tb_ram_sync_nr2w_clr.sv
// Directed bench: three instances (bypass, no bypass, depth 20 with nonzero clear value).
module tb_ram_sync_nr2w_clr;

    localparam int NP = 6;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [DW-1:0] CV20 = 32'h0000_005A;

    logic             clk;
    logic             reset_x;
    logic [NP*AW-1:0] raddr;
    logic [NP*DW-1:0] rdata_a, rdata_b, rdata_c;
    logic [AW-1:0]    waddr1, waddr2;
    logic [DW-1:0]    wdata1, wdata2;
    logic             we1, we2, clr_req;
    logic             ready_a, ready_b, ready_c;

    int checks = 0;
    int errors = 0;

    ram_sync_nr2w_clr #(.DATA_DEPTH(32), .BYPASS(1)) dut_a (
        .clk(clk), .reset_x(reset_x), .raddr(raddr), .rdata(rdata_a),
        .waddr1(waddr1), .waddr2(waddr2), .wdata1(wdata1), .wdata2(wdata2),
        .we1(we1), .we2(we2), .clr_req(clr_req), .ready(ready_a));

    ram_sync_nr2w_clr #(.DATA_DEPTH(32), .BYPASS(0)) dut_b (
        .clk(clk), .reset_x(reset_x), .raddr(raddr), .rdata(rdata_b),
        .waddr1(waddr1), .waddr2(waddr2), .wdata1(wdata1), .wdata2(wdata2),
        .we1(we1), .we2(we2), .clr_req(clr_req), .ready(ready_b));

    ram_sync_nr2w_clr #(.DATA_DEPTH(20), .BYPASS(1), .CLEAR_VALUE(CV20)) dut_c (
        .clk(clk), .reset_x(reset_x), .raddr(raddr), .rdata(rdata_c),
        .waddr1(waddr1), .waddr2(waddr2), .wdata1(wdata1), .wdata2(wdata2),
        .we1(we1), .we2(we2), .clr_req(clr_req), .ready(ready_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we1;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          we2;
        logic [AW-1:0] wa2;
        logic [DW-1:0] wd2;
        int            port;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp_byp;
        logic [DW-1:0] exp_nobyp;
    } vec_t;

    vec_t vt[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] slice(input logic [NP*DW-1:0] v, input int p);
        return v[p*DW +: DW];
    endfunction

    task automatic set_read(input int p, input logic [AW-1:0] a);
        raddr = '0;
        raddr[p*AW +: AW] = a;
    endtask

    // Counts edges until each sweep ends; optionally drives ignored writes during it.
    task automatic wait_ready(input string name, input bit traffic);
        int ca = -1;
        int cc = -1;
        for (int n = 1; n <= 100; n++) begin
            if (traffic) begin
                we1    = 1'b1;
                waddr1 = AW'(n);
                wdata1 = 32'h0000_00FF;
                set_read(0, AW'(n));
            end
            step();
            if (ready_c && cc < 0) cc = n;
            if (ready_a && ca < 0) ca = n;
            if (traffic && !ready_a) check({name, "_rd_in_sweep"}, slice(rdata_a, 0), 32'h0);
            if (ca >= 0 && cc >= 0) break;
        end
        we1 = 1'b0;
        check({name, "_sweep32"}, DW'(ca), 32'd32);
        check({name, "_sweep20"}, DW'(cc), 32'd20);
    endtask

    initial begin
        reset_x = 1'b1;
        raddr = '0; waddr1 = '0; waddr2 = '0; wdata1 = '0; wdata2 = '0;
        we1 = 1'b0; we2 = 1'b0; clr_req = 1'b0;

        vt[0] = '{1'b1, 5'd5,  32'hDEAD, 1'b0, 5'd0, 32'h0, 0, 5'd5,  32'hDEAD, 32'h0};
        vt[1] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0, 0, 5'd5,  32'hDEAD, 32'hDEAD};
        vt[2] = '{1'b1, 5'd3,  32'h11,   1'b0, 5'd0, 32'h0, 2, 5'd3,  32'h11,   32'h0};
        vt[3] = '{1'b1, 5'd7,  32'hA,    1'b1, 5'd7, 32'hB, 1, 5'd7,  32'hB,    32'h0};
        vt[4] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0, 1, 5'd7,  32'hB,    32'hB};
        vt[5] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0, 5, 5'd3,  32'h11,   32'h11};
        vt[6] = '{1'b1, 5'd4,  32'h33,   1'b1, 5'd3, 32'h22, 3, 5'd4, 32'h33,   32'h0};
        vt[7] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0, 4, 5'd3,  32'h22,   32'h22};
        vt[8] = '{1'b1, 5'd31, 32'h55,   1'b0, 5'd0, 32'h0, 0, 5'd31, 32'h55,   32'h0};
        vt[9] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0, 0, 5'd31, 32'h55,   32'h55};

        // Reset state.
        #2 reset_x = 1'b0;
        step(); step(); step();
        check("rst_ready", DW'(ready_a), 32'h0);
        check("rst_rdata_a", slice(rdata_a, 5), 32'h0);
        check("rst_rdata_c", slice(rdata_c, 2), CV20);

        // Release and time the initial sweep.
        reset_x = 1'b1;
        wait_ready("init", 1'b0);

        for (int a = 0; a < 32; a++) begin
            set_read(a % NP, AW'(a));
            step();
            check("init_zero_a", slice(rdata_a, a % NP), 32'h0);
            check("init_zero_b", slice(rdata_b, a % NP), 32'h0);
        end

        // Vector table: writes, bypass, collision, last address.
        for (int i = 0; i < 10; i++) begin
            we1 = vt[i].we1; waddr1 = vt[i].wa1; wdata1 = vt[i].wd1;
            we2 = vt[i].we2; waddr2 = vt[i].wa2; wdata2 = vt[i].wd2;
            set_read(vt[i].port, vt[i].ra);
            step();
            check($sformatf("vec%0d_byp", i),   slice(rdata_a, vt[i].port), vt[i].exp_byp);
            check($sformatf("vec%0d_nobyp", i), slice(rdata_b, vt[i].port), vt[i].exp_nobyp);
        end
        we1 = 1'b0; we2 = 1'b0;

        // Out-of-range handling on the depth-20 instance.
        we1 = 1'b1; waddr1 = 5'd25; wdata1 = 32'h77;
        set_read(0, 5'd25);
        step();
        we1 = 1'b0;
        check("oor_byp_a", slice(rdata_a, 0), 32'h77);
        check("oor_byp_c", slice(rdata_c, 0), CV20);
        step();
        check("oor_read_a", slice(rdata_a, 0), 32'h77);
        check("oor_read_c", slice(rdata_c, 0), CV20);
        set_read(3, 5'd31);
        step();
        check("oor31_c", slice(rdata_c, 3), CV20);
        check("last_a", slice(rdata_a, 3), 32'h55);

        // Clear request with traffic during the sweep.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("clr_ready_low", DW'(ready_a), 32'h0);
        wait_ready("clr", 1'b1);
        for (int a = 0; a < 32; a++) begin
            set_read(a % NP, AW'(a));
            step();
            check("clr_zero_a", slice(rdata_a, a % NP), 32'h0);
        end

        // Asynchronous reset clears registered read data.
        we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'hCAFE;
        set_read(0, 5'd2);
        step();
        we1 = 1'b0;
        check("pre_rst_data", slice(rdata_a, 0), 32'hCAFE);
        #2 reset_x = 1'b0;
        #1;
        check("async_rst_data", slice(rdata_a, 0), 32'h0);
        check("async_rst_ready", DW'(ready_a), 32'h0);
        step();
        reset_x = 1'b1;
        wait_ready("rst2", 1'b0);

        // Reset at sweep cycle 10 restarts the sweep.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 9; k++) step();
        reset_x = 1'b0;
        #1;
        check("mid_rst_ready", DW'(ready_a), 32'h0);
        step(); step();
        reset_x = 1'b1;
        wait_ready("mid", 1'b0);
        set_read(1, 5'd7);
        step();
        check("mid_after_a", slice(rdata_a, 1), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
